river_crossing_ctrl: RTL and testbench

//  Sequential controller for the farmer/cabbage/goat/wolf river-crossing puzzle.

---
 rtl/river_crossing_ctrl.sv | 121 ++++++++++++
 tb/tb_river_crossing_ctrl.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/river_crossing_ctrl.sv
// rtl/river_crossing_ctrl.sv - farmer/cabbage/goat/wolf river-crossing game controller
module river_crossing_ctrl #(
    parameter int MOVE_W    = 4,
    parameter int MAX_MOVES = 15,
    parameter int STRICT    = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              restart,
    input  logic              move_valid,
    input  logic [1:0]        move_sel,
    output logic              move_ready,
    output logic [3:0]        pos,
    output logic              alarm,
    output logic              reject,
    output logic [1:0]        reject_code,
    output logic [MOVE_W-1:0] move_count,
    output logic [1:0]        state
);

    typedef enum logic [1:0] {
        ST_PLAY  = 2'b00,
        ST_WON   = 2'b01,
        ST_LOST  = 2'b10,
        ST_LIMIT = 2'b11
    } state_t;

    localparam logic [MOVE_W-1:0] MAX_CNT = MOVE_W'(MAX_MOVES);

    // pos bit order is {farmer, cabbage, goat, wolf}
    function automatic logic unsafe(input logic [3:0] p);
        return ((p[1] == p[0]) && (p[3] != p[1])) ||
               ((p[2] == p[1]) && (p[3] != p[1]));
    endfunction

    state_t            state_q, state_d;
    logic [3:0]        pos_q, pos_d;
    logic [MOVE_W-1:0] count_q, count_d;
    logic              reject_q, reject_d;
    logic [1:0]        code_q, code_d;

    logic [3:0]        move_mask;
    logic [3:0]        next_pos;
    logic              item_bit;
    logic [MOVE_W-1:0] count_inc;

    // Decode the move: farmer always crosses, optionally carrying one item
    always_comb begin
        move_mask = 4'b1000;
        item_bit  = pos_q[3];
        case (move_sel)
            2'b01: begin move_mask = 4'b1100; item_bit = pos_q[2]; end
            2'b10: begin move_mask = 4'b1010; item_bit = pos_q[1]; end
            2'b11: begin move_mask = 4'b1001; item_bit = pos_q[0]; end
            default: begin move_mask = 4'b1000; item_bit = pos_q[3]; end
        endcase
        next_pos  = pos_q ^ move_mask;
        count_inc = count_q + 1'b1;
    end

    // Next-state: restart first, then validate and apply a sampled move
    always_comb begin
        state_d  = state_q;
        pos_d    = pos_q;
        count_d  = count_q;
        reject_d = 1'b0;
        code_d   = code_q;
        if (restart) begin
            state_d = ST_PLAY;
            pos_d   = 4'b0000;
            count_d = '0;
            code_d  = 2'b00;
        end else if (move_valid && (state_q == ST_PLAY)) begin
            if (item_bit != pos_q[3]) begin
                reject_d = 1'b1;
                code_d   = 2'b01;
            end else if (unsafe(next_pos) && (STRICT == 0)) begin
                reject_d = 1'b1;
                code_d   = 2'b10;
            end else begin
                pos_d   = next_pos;
                count_d = count_inc;
                if (unsafe(next_pos)) begin
                    state_d = ST_LOST;
                end else if (next_pos == 4'b1111) begin
                    state_d = ST_WON;
                end else if (count_inc == MAX_CNT) begin
                    state_d = ST_LIMIT;
                end else begin
                    state_d = ST_PLAY;
                end
            end
        end
    end

    // Game registers; async reset clears any move sampled on the same edge
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= ST_PLAY;
            pos_q    <= 4'b0000;
            count_q  <= '0;
            reject_q <= 1'b0;
            code_q   <= 2'b00;
        end else begin
            state_q  <= state_d;
            pos_q    <= pos_d;
            count_q  <= count_d;
            reject_q <= reject_d;
            code_q   <= code_d;
        end
    end

    assign move_ready  = (state_q == ST_PLAY);
    assign pos         = pos_q;
    assign alarm       = unsafe(pos_q);
    assign reject      = reject_q;
    assign reject_code = code_q;
    assign move_count  = count_q;
    assign state       = state_q;

endmodule

// File: tb/tb_river_crossing_ctrl.sv
// tb/tb_river_crossing_ctrl.sv - scoreboard bench for river_crossing_ctrl in four configurations
module tb_river_crossing_ctrl;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       restart = 1'b0;
    logic       move_valid = 1'b0;
    logic [1:0] move_sel = 2'b00;

    logic       ready_o [4];
    logic [3:0] pos_o   [4];
    logic       alarm_o [4];
    logic       rej_o   [4];
    logic [1:0] code_o  [4];
    logic [3:0] cnt_o   [4];
    logic [1:0] st_o    [4];

    int errors = 0;
    int checks = 0;

    // Instances: 0 strict/15, 1 practice/15, 2 strict/3, 3 strict/7
    for (genvar g = 0; g < 4; g++) begin : g_dut
        river_crossing_ctrl #(
            .MOVE_W   (4),
            .MAX_MOVES((g == 2) ? 3 : ((g == 3) ? 7 : 15)),
            .STRICT   ((g == 1) ? 0 : 1)
        ) dut (
            .clk        (clk),
            .reset      (reset),
            .restart    (restart),
            .move_valid (move_valid),
            .move_sel   (move_sel),
            .move_ready (ready_o[g]),
            .pos        (pos_o[g]),
            .alarm      (alarm_o[g]),
            .reject     (rej_o[g]),
            .reject_code(code_o[g]),
            .move_count (cnt_o[g]),
            .state      (st_o[g])
        );
    end

    // Free-running clock
    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0]      rdy;
        logic [3:0][3:0] pos;
        logic [3:0]      alm;
        logic [3:0]      rej;
        logic [3:0][1:0] code;
        logic [3:0][3:0] cnt;
        logic [3:0][1:0] st;
    } exp_t;

    exp_t sb[$];

    // Reference model: bank of each character (0 farmer, 1 cabbage, 2 goat, 3 wolf)
    bit bk     [4][4];
    int cnt_m  [4];
    int st_m   [4];
    bit rej_m  [4];
    int code_m [4];
    int strict_p [4];
    int max_p    [4];

    function automatic bit unsafe_b(input bit f, input bit c, input bit g, input bit w);
        return ((g == w) && (f != g)) || ((c == g) && (f != g));
    endfunction

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, req, $time);
        end
    endtask

    task automatic init_one(input int i);
        for (int k = 0; k < 4; k++) bk[i][k] = 1'b0;
        cnt_m[i]  = 0;
        st_m[i]   = 0;
        rej_m[i]  = 1'b0;
        code_m[i] = 0;
    endtask

    task automatic model_init();
        for (int i = 0; i < 4; i++) init_one(i);
    endtask

    task automatic model_step(input bit v, input int sel, input bit rs);
        bit nb [4];
        bool_loop: for (int i = 0; i < 4; i++) begin
            rej_m[i] = 1'b0;
            if (rs) begin
                init_one(i);
            end else if (v && st_m[i] == 0) begin
                for (int k = 0; k < 4; k++) nb[k] = bk[i][k];
                nb[0] = ~nb[0];
                if (sel != 0 && bk[i][sel] != bk[i][0]) begin
                    rej_m[i]  = 1'b1;
                    code_m[i] = 1;
                end else begin
                    if (sel != 0) nb[sel] = ~nb[sel];
                    if (unsafe_b(nb[0], nb[1], nb[2], nb[3]) && strict_p[i] == 0) begin
                        rej_m[i]  = 1'b1;
                        code_m[i] = 2;
                    end else begin
                        for (int k = 0; k < 4; k++) bk[i][k] = nb[k];
                        cnt_m[i]++;
                        if (unsafe_b(nb[0], nb[1], nb[2], nb[3])) st_m[i] = 2;
                        else if (nb[0] && nb[1] && nb[2] && nb[3]) st_m[i] = 1;
                        else if (cnt_m[i] == max_p[i]) st_m[i] = 3;
                    end
                end
            end
        end
    endtask

    task automatic push_exp();
        exp_t e;
        for (int i = 0; i < 4; i++) begin
            e.pos[i]  = {bk[i][0], bk[i][1], bk[i][2], bk[i][3]};
            e.cnt[i]  = 4'(cnt_m[i]);
            e.st[i]   = 2'(st_m[i]);
            e.rej[i]  = rej_m[i];
            e.code[i] = 2'(code_m[i]);
            e.alm[i]  = unsafe_b(bk[i][0], bk[i][1], bk[i][2], bk[i][3]);
            e.rdy[i]  = (st_m[i] == 0);
        end
        sb.push_back(e);
    endtask

    task automatic step(input bit v, input logic [1:0] sel, input bit rs);
        @(negedge clk);
        move_valid = v;
        move_sel   = sel;
        restart    = rs;
        model_step(v, int'(sel), rs);
        push_exp();
    endtask

    task automatic check_init_direct(input string tag);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("%s dut%0d pos", tag, i), int'(pos_o[i]), 0);
            chk($sformatf("%s dut%0d count", tag, i), int'(cnt_o[i]), 0);
            chk($sformatf("%s dut%0d state", tag, i), int'(st_o[i]), 0);
            chk($sformatf("%s dut%0d reject", tag, i), int'(rej_o[i]), 0);
            chk($sformatf("%s dut%0d ready", tag, i), int'(ready_o[i]), 1);
        end
    endtask

    // Monitor: after each active edge, pop the expected snapshot and compare
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                for (int i = 0; i < 4; i++) begin
                    chk($sformatf("dut%0d pos", i), int'(pos_o[i]), int'(e.pos[i]));
                    chk($sformatf("dut%0d count", i), int'(cnt_o[i]), int'(e.cnt[i]));
                    chk($sformatf("dut%0d state", i), int'(st_o[i]), int'(e.st[i]));
                    chk($sformatf("dut%0d reject", i), int'(rej_o[i]), int'(e.rej[i]));
                    chk($sformatf("dut%0d reject_code", i), int'(code_o[i]), int'(e.code[i]));
                    chk($sformatf("dut%0d alarm", i), int'(alarm_o[i]), int'(e.alm[i]));
                    chk($sformatf("dut%0d move_ready", i), int'(ready_o[i]), int'(e.rdy[i]));
                end
            end
        end
    end

    // Stimulus: directed puzzle scenarios followed by randomized play
    initial begin
        logic [1:0] win_seq [7];
        win_seq = '{2'b10, 2'b00, 2'b01, 2'b10, 2'b11, 2'b00, 2'b10};
        strict_p = '{1, 0, 1, 1};
        max_p    = '{15, 15, 3, 7};
        model_init();

        repeat (2) @(negedge clk);
        check_init_direct("reset");
        reset = 1'b0;

        foreach (win_seq[k]) step(1'b1, win_seq[k], 1'b0);
        step(1'b1, 2'b00, 1'b0);
        step(1'b0, 2'b00, 1'b0);
        step(1'b0, 2'b00, 1'b1);

        step(1'b1, 2'b00, 1'b0);
        step(1'b1, 2'b00, 1'b0);
        step(1'b1, 2'b10, 1'b0);
        step(1'b1, 2'b01, 1'b0);
        step(1'b0, 2'b00, 1'b0);
        step(1'b0, 2'b00, 1'b1);

        repeat (3) step(1'b1, 2'b10, 1'b0);
        step(1'b0, 2'b00, 1'b1);

        step(1'b1, 2'b10, 1'b0);
        step(1'b1, 2'b00, 1'b0);
        step(1'b1, 2'b01, 1'b0);
        step(1'b1, 2'b10, 1'b0);
        @(negedge clk);
        move_valid = 1'b1;
        move_sel   = 2'b11;
        restart    = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        check_init_direct("async_reset");
        model_init();
        push_exp();
        @(negedge clk);
        reset      = 1'b0;
        move_valid = 1'b0;
        model_step(1'b0, 0, 1'b0);
        push_exp();

        step(1'b1, 2'b10, 1'b0);
        step(1'b1, 2'b00, 1'b1);
        step(1'b1, 2'b10, 1'b1);

        for (int n = 0; n < 400; n++) begin
            step($urandom_range(0, 3) != 0, 2'($urandom_range(0, 3)),
                 $urandom_range(0, 11) == 0);
        end

        @(negedge clk);
        move_valid = 1'b0;
        restart    = 1'b0;
        repeat (2) @(negedge clk);
        chk("scoreboard_drained", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
